// File: rtl/control_unit.sv
// Three-phase sequencer/decoder for the 8-bit CPU datapath: FETCH latches the
// instruction, EXEC drives the operation, PCUPD advances or redirects the PC.
module control_unit #(
    parameter int CW_W  = 22,
    parameter int RET_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       I,
    input  logic [3:0]        alu_status_latched,
    output logic [CW_W-1:0]   control_word,
    output logic [7:0]        K,
    output logic              halted,
    output logic [RET_W-1:0]  retired
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_PCUPD = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic       sl;
        logic       il;
        logic       pcl;
        logic       mr;
        logic       mw;
        logic       b_sel;
        logic       a_sel;
        logic       en_alu;
        logic       ci;
        logic [2:0] fs;
        logic       w;
        logic [2:0] sb;
        logic [2:0] sa;
        logic [2:0] da;
    } cw_t;

    localparam logic [3:0] OP_ALU  = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0011;
    localparam logic [3:0] OP_ST   = 4'b0100;
    localparam logic [3:0] OP_JMP  = 4'b0101;
    localparam logic [3:0] OP_BZ   = 4'b0110;
    localparam logic [3:0] OP_BC   = 4'b0111;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [2:0] FS_ADD = 3'b000;
    localparam logic [2:0] FS_SUB = 3'b001;
    localparam logic [2:0] FS_AND = 3'b010;

    state_t           state_reg;
    state_t           state_next;
    logic [RET_W-1:0] retired_reg;
    cw_t              cw_next;
    logic [7:0]       k_next;

    logic [3:0] opcode;
    logic [2:0] rd;
    logic       flag_z;
    logic       flag_c;
    logic       branch_taken;
    logic       unused_flags;

    assign opcode = I[15:12];
    assign rd     = I[11:9];
    assign flag_z = alu_status_latched[0];
    assign flag_c = alu_status_latched[1];
    // N and V are reported by the datapath but no branch in this ISA tests them.
    assign unused_flags = ^alu_status_latched[3:2];

    always_comb begin
        branch_taken = 1'b0;
        case (opcode)
            OP_JMP:  branch_taken = 1'b1;
            OP_BZ:   branch_taken = flag_z;
            OP_BC:   branch_taken = flag_c;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        cw_next    = '0;
        k_next     = 8'h00;
        state_next = state_reg;

        case (state_reg)
            ST_FETCH: begin
                cw_next.il = 1'b1;
                state_next = ST_EXEC;
            end

            ST_EXEC: begin
                state_next = (opcode == OP_HALT) ? ST_HALT : ST_PCUPD;
                case (opcode)
                    OP_ALU: begin
                        cw_next.da     = rd;
                        cw_next.sa     = I[8:6];
                        cw_next.sb     = I[5:3];
                        cw_next.fs     = I[2:0];
                        cw_next.ci     = (I[2:0] == FS_SUB);
                        cw_next.w      = 1'b1;
                        cw_next.en_alu = 1'b1;
                        cw_next.sl     = 1'b1;
                    end
                    OP_ADDI: begin
                        cw_next.da     = rd;
                        cw_next.sa     = rd;
                        cw_next.b_sel  = 1'b1;
                        cw_next.fs     = FS_ADD;
                        cw_next.en_alu = 1'b1;
                        cw_next.w      = 1'b1;
                        cw_next.sl     = 1'b1;
                        k_next         = I[7:0];
                    end
                    OP_LD: begin
                        cw_next.mr = 1'b1;
                        cw_next.w  = 1'b1;
                        cw_next.da = rd;
                        k_next     = I[7:0];
                    end
                    OP_ST: begin
                        // rd AND rd puts the register value onto the data bus
                        cw_next.mw     = 1'b1;
                        cw_next.en_alu = 1'b1;
                        cw_next.fs     = FS_AND;
                        cw_next.sa     = rd;
                        cw_next.sb     = rd;
                        k_next         = I[7:0];
                    end
                    default: begin
                        cw_next = '0;
                    end
                endcase
            end

            ST_PCUPD: begin
                cw_next.pcl    = 1'b1;
                cw_next.a_sel  = 1'b1;
                cw_next.b_sel  = 1'b1;
                cw_next.en_alu = 1'b1;
                cw_next.fs     = FS_ADD;
                // Taken: PC + signed offset; otherwise PC + 0 + carry-in = PC + 1
                if (branch_taken) begin
                    k_next     = I[7:0];
                    cw_next.ci = 1'b0;
                end else begin
                    k_next     = 8'h00;
                    cw_next.ci = 1'b1;
                end
                state_next = ST_FETCH;
            end

            ST_HALT: begin
                state_next = ST_HALT;
            end

            default: begin
                state_next = ST_FETCH;
            end
        endcase

        if (rst) begin
            cw_next = '0;
            k_next  = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_FETCH;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_PCUPD) begin
                retired_reg <= retired_reg + 1'b1;
            end
        end
    end

    assign control_word = cw_next;
    assign K            = k_next;
    assign halted       = (state_reg == ST_HALT) && !rst;
    assign retired      = retired_reg;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: table of single-instruction vectors checked
// phase by phase, plus hand sequences for reset, HALT, counter wrap and aborts.
module tb_control_unit;

    logic        clk;
    logic        rst;
    logic [15:0] instr;
    logic [3:0]  flags;
    logic [21:0] control_word;
    logic [7:0]  k_out;
    logic        halted;
    logic [7:0]  retired;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_retired;

    control_unit dut (
        .clk                (clk),
        .rst                (rst),
        .I                  (instr),
        .alu_status_latched (flags),
        .control_word       (control_word),
        .K                  (k_out),
        .halted             (halted),
        .retired            (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [21:0] CW_FETCH   = 22'h100000;
    localparam logic [21:0] CW_PC_NEXT = 22'h09E000;
    localparam logic [21:0] CW_PC_JUMP = 22'h09C000;

    typedef struct {
        string       name;
        logic [15:0] instr;
        logic [3:0]  flags;
        logic [21:0] exec_cw;
        logic [7:0]  exec_k;
        logic [21:0] pc_cw;
        logic [7:0]  pc_k;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_retired = 8'h00;
    endtask

    // Runs one full instruction starting in FETCH; returns after PCUPD -> FETCH.
    task automatic run_nop();
        instr = 16'h2000;
        step();
        step();
        step();
        exp_retired = exp_retired + 8'h01;
    endtask

    initial begin
        rst   = 1'b1;
        instr = 16'h0000;
        flags = 4'h0;
        exp_retired = 8'h00;

        vecs[0]  = '{"add",    16'h0A50, 4'b0000, 22'h20428D, 8'h00, CW_PC_NEXT, 8'h00};
        vecs[1]  = '{"sub",    16'h0A51, 4'b0000, 22'h20668D, 8'h00, CW_PC_NEXT, 8'h00};
        vecs[2]  = '{"alu_r7", 16'h0FFF, 4'b0000, 22'h205FFF, 8'h00, CW_PC_NEXT, 8'h00};
        vecs[3]  = '{"addi",   16'h1605, 4'b0000, 22'h21421B, 8'h05, CW_PC_NEXT, 8'h00};
        vecs[4]  = '{"ld",     16'h3A11, 4'b0000, 22'h040205, 8'h11, CW_PC_NEXT, 8'h00};
        vecs[5]  = '{"st",     16'h4680, 4'b0000, 22'h0248D8, 8'h80, CW_PC_NEXT, 8'h00};
        vecs[6]  = '{"bz_t",   16'h60FE, 4'b0001, 22'h000000, 8'h00, CW_PC_JUMP, 8'hFE};
        vecs[7]  = '{"bz_nt",  16'h60FE, 4'b0010, 22'h000000, 8'h00, CW_PC_NEXT, 8'h00};
        vecs[8]  = '{"bc_t",   16'h7010, 4'b0010, 22'h000000, 8'h00, CW_PC_JUMP, 8'h10};
        vecs[9]  = '{"bc_nt",  16'h7010, 4'b0001, 22'h000000, 8'h00, CW_PC_NEXT, 8'h00};
        vecs[10] = '{"jmp",    16'h5005, 4'b0000, 22'h000000, 8'h00, CW_PC_JUMP, 8'h05};
        vecs[11] = '{"nop",    16'h2123, 4'b1111, 22'h000000, 8'h00, CW_PC_NEXT, 8'h00};

        // Reset: outputs forced to zero while rst is high
        step();
        check("rst_cw", {10'h0, control_word}, 32'h0);
        check("rst_k", {24'h0, k_out}, 32'h0);
        step();
        check("rst_cw2", {10'h0, control_word}, 32'h0);
        rst = 1'b0;
        #1;
        check("fetch_cw_after_rst", {10'h0, control_word}, {10'h0, CW_FETCH});
        check("retired_after_rst", {24'h0, retired}, 32'h0);
        check("halted_after_rst", {31'h0, halted}, 32'h0);

        for (int i = 0; i < 12; i++) begin
            instr = vecs[i].instr;
            flags = vecs[i].flags;
            #1;
            check({vecs[i].name, "_fetch_cw"}, {10'h0, control_word}, {10'h0, CW_FETCH});
            step();
            check({vecs[i].name, "_exec_cw"}, {10'h0, control_word}, {10'h0, vecs[i].exec_cw});
            check({vecs[i].name, "_exec_k"}, {24'h0, k_out}, {24'h0, vecs[i].exec_k});
            step();
            check({vecs[i].name, "_pc_cw"}, {10'h0, control_word}, {10'h0, vecs[i].pc_cw});
            check({vecs[i].name, "_pc_k"}, {24'h0, k_out}, {24'h0, vecs[i].pc_k});
            check({vecs[i].name, "_ret_pre"}, {24'h0, retired}, {24'h0, exp_retired});
            step();
            exp_retired = exp_retired + 8'h01;
            check({vecs[i].name, "_ret_post"}, {24'h0, retired}, {24'h0, exp_retired});
            $display("vec %0d %s instr=%h retired=%0d", i, vecs[i].name, vecs[i].instr, retired);
        end

        // HALT: cw/K stay zero, retired frozen, only rst leaves
        flags = 4'h0;
        instr = 16'hF000;
        step();
        check("halt_exec_cw", {10'h0, control_word}, 32'h0);
        check("halt_exec_halted", {31'h0, halted}, 32'h0);
        step();
        check("halt_halted", {31'h0, halted}, 32'h1);
        for (int c = 0; c < 20; c++) begin
            check("halt_hold_cw", {10'h0, control_word}, 32'h0);
            check("halt_hold_k", {24'h0, k_out}, 32'h0);
            check("halt_hold_ret", {24'h0, retired}, {24'h0, exp_retired});
            check("halt_hold_halted", {31'h0, halted}, 32'h1);
            step();
        end
        $display("halt held 20 cycles retired=%0d", retired);
        do_reset();
        #1;
        check("halt_exit_halted", {31'h0, halted}, 32'h0);
        check("halt_exit_cw", {10'h0, control_word}, {10'h0, CW_FETCH});

        // Counter wrap
        for (int n = 0; n < 255; n++) begin
            run_nop();
        end
        check("ret_ff", {24'h0, retired}, 32'h000000FF);
        run_nop();
        check("ret_wrap", {24'h0, retired}, 32'h0);
        $display("wrap sequence retired=%0d", retired);
        run_nop();
        run_nop();
        check("ret_after_wrap", {24'h0, retired}, 32'h2);

        // Reset during PCUPD aborts without retiring
        instr = 16'h2000;
        step();
        step();
        check("abort_pc_cw", {10'h0, control_word}, {10'h0, CW_PC_NEXT});
        rst = 1'b1;
        #1;
        check("abort_pc_cw_rst", {10'h0, control_word}, 32'h0);
        step();
        rst = 1'b0;
        #1;
        check("abort_pc_ret", {24'h0, retired}, 32'h0);
        check("abort_pc_fetch", {10'h0, control_word}, {10'h0, CW_FETCH});
        $display("abort in PCUPD retired=%0d", retired);

        // Reset during EXEC
        run_nop();
        instr = 16'h0A50;
        step();
        check("abort_ex_cw", {10'h0, control_word}, 32'h0020428D);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("abort_ex_fetch", {10'h0, control_word}, {10'h0, CW_FETCH});
        check("abort_ex_ret", {24'h0, retired}, 32'h0);
        $display("abort in EXEC retired=%0d", retired);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
